// File: rtl/sap_core_if.sv
// rtl/sap_core_if.sv - host program/run/output handshake bundle for sap_core
interface sap_core_if #(
  parameter int DATA_W = 8
) ();
  localparam int ADDR_W = DATA_W - 4;

  logic              run;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              halted;
  logic              flag_c;
  logic              flag_z;

  // host / consumer side
  modport master (
    output run, prog_we, prog_addr, prog_wdata, out_ready,
    input  out_data, out_valid, halted, flag_c, flag_z
  );

  // core side
  modport slave (
    input  run, prog_we, prog_addr, prog_wdata, out_ready,
    output out_data, out_valid, halted, flag_c, flag_z
  );
endinterface

// File: rtl/sap_core.sv
// rtl/sap_core.sv - parametrised accumulator processor with internal RAM and OUT handshake
module sap_core #(
  parameter int DATA_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  sap_core_if.slave   bus
);
  localparam int ADDR_W = DATA_W - 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_OUTW
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              c_q, c_d;
  logic              z_q, z_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;

  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign operand   = ir_q[ADDR_W-1:0];
  assign ram_rdata = mem_q[mar_q];
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = a_q - b_q;

  assign bus.out_data  = out_q;
  assign bus.out_valid = (state_q == S_OUTW);
  assign bus.halted    = (state_q == S_IDLE);
  assign bus.flag_c    = c_q;
  assign bus.flag_z    = z_q;

  // state and datapath registers; RAM contents are deliberately outside reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // single write port shared by host loading (IDLE only) and STA (T4 only)
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

  // microsequencer: next state and register updates for each T-state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    c_d       = c_q;
    z_d       = z_q;
    ram_we    = 1'b0;
    ram_waddr = bus.prog_addr;
    ram_wdata = bus.prog_wdata;

    unique case (state_q)
      S_IDLE: begin
        ram_we = bus.prog_we;
        if (bus.run) begin
          state_d = S_T1;
          pc_d    = '0;
        end
      end
      S_T1: begin
        mar_d   = pc_q;
        state_d = S_T2;
      end
      S_T2: begin
        ir_d    = ram_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = operand;
            state_d = S_T4;
          end
          OP_LDI: a_d = {{(DATA_W - ADDR_W){1'b0}}, operand};
          OP_JMP: pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_OUT: begin
            out_d   = a_q;
            state_d = S_OUTW;
          end
          OP_HLT: state_d = S_IDLE;
          default: ;
        endcase
      end
      S_T4: begin
        state_d = S_T1;
        case (opcode)
          OP_LDA: a_d = ram_rdata;
          OP_ADD, OP_SUB: begin
            b_d     = ram_rdata;
            state_d = S_T5;
          end
          OP_STA: begin
            ram_we    = 1'b1;
            ram_waddr = mar_q;
            ram_wdata = a_q;
          end
          default: ;
        endcase
      end
      S_T5: begin
        state_d = S_T1;
        if (opcode == OP_SUB) begin
          a_d = diff;
          c_d = (a_q >= b_q);
          z_d = (diff == '0);
        end else begin
          a_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
          z_d = (sum[DATA_W-1:0] == '0);
        end
      end
      S_OUTW: begin
        if (bus.out_ready) begin
          state_d = S_T1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sap_core.sv
// tb/tb_sap_core.sv - self-checking bench for sap_core against an instruction-level model
`timescale 1ns/1ps
module tb_sap_core;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sap_core_if #(.DATA_W(DATA_W)) bus ();

  sap_core #(.DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // instruction-level model state
  logic [7:0] m_ram [DEPTH];
  logic [7:0] m_a, m_out;
  logic       m_c, m_z;
  logic [7:0] img [DEPTH];

  // expected per-cycle trace, index 0 = first cycle after the run edge
  bit         e_halt[$], e_valid[$], e_c[$], e_z[$], e_rdy[$], e_rst[$];
  logic [7:0] e_data[$];
  bit         trace_halted;
  int         stall_q[$];

  int         cur_j;
  bit         chk_on = 1'b0;
  int         valid_cnt;
  logic [7:0] last_out;
  bit         force_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare process: every traced cycle, mid-cycle
  always @(negedge clock) begin
    if (chk_on) begin
      check($sformatf("halted[%0d]", cur_j), bus.halted, e_halt[cur_j]);
      check($sformatf("out_valid[%0d]", cur_j), bus.out_valid, e_valid[cur_j]);
      check($sformatf("out_data[%0d]", cur_j), bus.out_data, e_data[cur_j]);
      check($sformatf("flag_c[%0d]", cur_j), bus.flag_c, e_c[cur_j]);
      check($sformatf("flag_z[%0d]", cur_j), bus.flag_z, e_z[cur_j]);
      if (bus.out_valid) begin
        valid_cnt++;
        last_out = bus.out_data;
      end
    end
  end

  function automatic void push(bit h, bit v, logic [7:0] d, bit c, bit z, bit r, bit rst);
    e_halt.push_back(h);
    e_valid.push_back(v);
    e_data.push_back(d);
    e_c.push_back(c);
    e_z.push_back(z);
    e_rdy.push_back(r);
    e_rst.push_back(rst);
  endfunction

  function automatic void model_reset();
    m_a = 8'h00; m_out = 8'h00; m_c = 1'b0; m_z = 1'b0;
  endfunction

  // execute whole instructions from PC=0; an instruction cut by the limit has no effect,
  // and the cycle at the limit becomes a reset cycle
  task automatic build_trace(input int limit);
    int         j, len, s;
    logic [3:0] pc, op, opd;
    logic [7:0] ins;
    logic [8:0] sum;
    e_halt.delete(); e_valid.delete(); e_data.delete(); e_c.delete();
    e_z.delete(); e_rdy.delete(); e_rst.delete();
    trace_halted = 1'b0;
    j  = 0;
    pc = 4'h0;
    while (!trace_halted && j < limit) begin
      ins = m_ram[pc];
      pc  = pc + 4'd1;
      op  = ins[7:4];
      opd = ins[3:0];
      s   = 0;
      case (op)
        4'h1, 4'h4: len = 4;
        4'h2, 4'h3: len = 5;
        4'hE: begin
          if (stall_q.size() > 0) s = stall_q.pop_front();
          else s = $urandom_range(0, 3);
          len = 4 + s;
        end
        default: len = 3;
      endcase
      for (int t = 0; t < len; t++) begin
        if (j + t < limit) begin
          if (op == 4'hE && t >= 3) push(1'b0, 1'b1, m_a, m_c, m_z, (t == len - 1), 1'b0);
          else push(1'b0, 1'b0, m_out, m_c, m_z, 1'($urandom_range(0, 1)), 1'b0);
        end
      end
      if (j + len <= limit) begin
        case (op)
          4'h1: m_a = m_ram[opd];
          4'h2: begin
            sum = {1'b0, m_a} + {1'b0, m_ram[opd]};
            m_a = sum[7:0]; m_c = sum[8]; m_z = (m_a == 8'h00);
          end
          4'h3: begin
            m_c = (m_a >= m_ram[opd]);
            m_a = m_a - m_ram[opd];
            m_z = (m_a == 8'h00);
          end
          4'h4: m_ram[opd] = m_a;
          4'h5: m_a = {4'h0, opd};
          4'h6: pc = opd;
          4'h7: if (m_c) pc = opd;
          4'h8: if (m_z) pc = opd;
          4'hE: m_out = m_a;
          4'hF: begin
            trace_halted = 1'b1;
            push(1'b1, 1'b0, m_out, m_c, m_z, 1'($urandom_range(0, 1)), 1'b0);
          end
          default: ;
        endcase
      end
      j += len;
    end
    if (!trace_halted) begin
      push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      model_reset();
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_wdata = d;
    m_ram[a] = d;
    @(posedge clock); #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic load_img();
    for (int i = 0; i < DEPTH; i++) load(4'(i), img[i]);
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'h00;
  endtask

  // pulse run (optionally with a same-edge host write), then drive and track the trace
  task automatic run_prog(input int limit, input bit allow_sim_we);
    bit         sim_we;
    logic [3:0] sa;
    logic [7:0] sd;
    sim_we = allow_sim_we && ($urandom_range(0, 1) == 1);
    sa = 4'($urandom);
    sd = 8'($urandom);
    if (sim_we) m_ram[sa] = sd;
    build_trace(limit);
    valid_cnt = 0;
    bus.run = 1'b1; bus.prog_we = sim_we; bus.prog_addr = sa; bus.prog_wdata = sd;
    @(posedge clock); #1;
    for (int j = 0; j < e_halt.size(); j++) begin
      cur_j = j;
      chk_on = 1'b1;
      bus.out_ready = e_rdy[j];
      if (e_rst[j]) begin
        reset = 1'b0; bus.run = 1'b0; bus.prog_we = 1'b0;
      end else if (e_halt[j]) begin
        bus.run = 1'b0; bus.prog_we = 1'b0;
      end else begin
        bus.run        = 1'($urandom_range(0, 1));
        bus.prog_we    = force_we | 1'($urandom_range(0, 1));
        bus.prog_addr  = force_we ? 4'hE : 4'($urandom);
        bus.prog_wdata = force_we ? 8'h55 : 8'($urandom);
      end
      @(posedge clock); #1;
    end
    chk_on = 1'b0;
    reset = 1'b1; bus.run = 1'b0; bus.prog_we = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset halted", bus.halted, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 8'h00);
    check("reset flag_c", bus.flag_c, 0);
    check("reset flag_z", bus.flag_z, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // 1) LDI 5; ADD E; OUT; HLT with RAM[E]=03
    clear_img();
    img[0] = 8'h55; img[1] = 8'h2E; img[2] = 8'hE0; img[3] = 8'hF0; img[14] = 8'h03;
    load_img();
    stall_q.push_back(0);
    run_prog(200, 1'b0);
    check("t1 trace length", e_halt.size(), 16);
    check("t1 out_data", last_out, 8'h08);
    check("t1 valid cycles", valid_cnt, 1);
    check("t1 halted", bus.halted, 1);
    check("t1 flag_c", bus.flag_c, 0);
    check("t1 flag_z", bus.flag_z, 0);

    // 2) LDI F; SUB E; JZ 5; (OUT at 3 must be skipped); HLT at 5
    clear_img();
    img[0] = 8'h5F; img[1] = 8'h3E; img[2] = 8'h85; img[3] = 8'hE0; img[5] = 8'hF0; img[14] = 8'h0F;
    load_img();
    run_prog(200, 1'b0);
    check("t2 trace length", e_halt.size(), 15);
    check("t2 model A", m_a, 8'h00);
    check("t2 flag_c", bus.flag_c, 1);
    check("t2 flag_z", bus.flag_z, 1);
    check("t2 valid cycles", valid_cnt, 0);

    // 3) LDA FF; ADD 01 -> 00 with C,Z; JC taken; LDI keeps flags
    clear_img();
    img[0] = 8'h1E; img[1] = 8'h2D; img[2] = 8'h74; img[3] = 8'hF0; img[4] = 8'h57;
    img[5] = 8'hE0; img[6] = 8'hF0; img[13] = 8'h01; img[14] = 8'hFF;
    load_img();
    stall_q.push_back(0);
    run_prog(200, 1'b0);
    check("t3 out_data", last_out, 8'h07);
    check("t3 flag_c", bus.flag_c, 1);
    check("t3 flag_z", bus.flag_z, 1);
    check("t3 valid cycles", valid_cnt, 1);

    // 4) OUT stalled for 10 cycles, then a second OUT
    clear_img();
    img[0] = 8'h5A; img[1] = 8'hE0; img[2] = 8'h5B; img[3] = 8'hE0; img[4] = 8'hF0;
    load_img();
    stall_q.push_back(10);
    stall_q.push_back(0);
    run_prog(200, 1'b0);
    check("t4 trace length", e_halt.size(), 28);
    check("t4 valid cycles", valid_cnt, 12);
    check("t4 out_data", last_out, 8'h0B);

    // 5) STA E then LDA E while the host keeps writing 55 to E
    clear_img();
    img[0] = 8'h5C; img[1] = 8'h4E; img[2] = 8'h53; img[3] = 8'h1E; img[4] = 8'hE0; img[5] = 8'hF0;
    load_img();
    stall_q.push_back(0);
    force_we = 1'b1;
    run_prog(200, 1'b0);
    force_we = 1'b0;
    check("t5 out_data", last_out, 8'h0C);
    check("t5 model RAM[E]", m_ram[14], 8'h0C);

    // 6) reset during OUTW, then during T4 of ADD, then a clean rerun
    clear_img();
    img[0] = 8'h55; img[1] = 8'h2E; img[2] = 8'hE0; img[3] = 8'hF0; img[14] = 8'h03;
    load_img();
    stall_q.push_back(20);
    run_prog(14, 1'b0);
    check("t6 outw cut length", e_halt.size(), 15);
    check("t6 outw valid cycles", valid_cnt, 3);
    run_prog(6, 1'b0);
    check("t6 t4 cut length", e_halt.size(), 7);
    stall_q.push_back(0);
    run_prog(200, 1'b0);
    check("t6 rerun out_data", last_out, 8'h08);
    check("t6 rerun valid cycles", valid_cnt, 1);

    // randomized programs, run limits cut some runs mid-instruction with reset
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
      load_img();
      run_prog($urandom_range(20, 150), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
